// File: rtl/enigma_uart_tx.sv
// rtl/enigma_uart_tx.sv - byte FIFO plus 8N1 UART serializer for the Enigma cipher output
module enigma_uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int ADDR_W       = 4
) (
    input  logic              i_clock,
    input  logic              reset,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_tx_serial,
    output logic              o_tx_active,
    output logic              o_tx_done,
    output logic [ADDR_W:0]   o_fifo_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    logic [7:0]        fifo_mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;
    logic              wr_en;
    logic              pop;

    tx_state_t         state;
    tx_state_t         state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_next;
    logic              tx_serial;
    logic              line_next;
    logic              baud_wrap;

    // Flags come straight from the registered count, so the FSM only ever sees
    // a byte one cycle after it was written.
    assign o_full       = (fifo_count == COUNT_FULL);
    assign o_empty      = (fifo_count == '0);
    assign o_fifo_count = fifo_count;
    assign o_overflow   = overflow;
    assign wr_en        = i_valid && !o_full;
    assign baud_wrap    = (baud_cnt == BAUD_LAST);

    assign o_tx_serial  = tx_serial;
    assign o_tx_active  = (state != ST_IDLE);
    assign o_tx_done    = (state == ST_STOP) && baud_wrap;

    // Byte storage; contents are don't-care after reset because the pointers restart.
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= i_data;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge i_clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + (ADDR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (ADDR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            // A write into a full FIFO is lost even if the FSM pops this cycle.
            if (i_valid && o_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame state register; the line is registered from the next-state decode.
    always_ff @(posedge i_clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_serial <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            tx_serial <= line_next;
        end
    end

    // Next-state, baud/bit sequencing, FIFO pop and next line level.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        pop        = 1'b0;
        line_next  = 1'b1;

        case (state)
            ST_IDLE: begin
                if (!o_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    baud_next  = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_wrap) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!o_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase

        case (state_next)
            ST_START: line_next = 1'b0;
            ST_DATA:  line_next = shift_next[bit_next];
            default:  line_next = 1'b1;
        endcase
    end

endmodule
